// File: rtl/ps2_scancode_decoder_if.sv
// Key-event bus between the PS/2 byte source and the scan-code decoder.
// master drives received bytes; slave (the decoder) returns decoded key events.
interface ps2_scancode_decoder_if #(
  parameter int CNT_W = 8
);
  logic             code_valid;
  logic [7:0]       code;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_make;
  logic             key_repeat;
  logic [7:0]       key_ascii;
  logic             key_down;
  logic [CNT_W-1:0] press_count;

  modport master (
    output code_valid, code,
    input  key_valid, key_code, key_ext, key_make, key_repeat,
           key_ascii, key_down, press_count
  );

  modport slave (
    input  code_valid, code,
    output key_valid, key_code, key_ext, key_make, key_repeat,
           key_ascii, key_down, press_count
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: strips E0/F0 prefixes and emits one registered key
// event per completed code, with repeat detection, shift-aware ASCII and a press counter.
module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   reset,
  ps2_scancode_decoder_if.slave bus_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } state_e;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;

  state_e           state_q, state_d;
  logic             evt_fire_d, evt_ext_d, evt_make_d;

  logic             key_valid_q;
  logic [7:0]       key_code_q;
  logic             key_ext_q;
  logic             key_make_q;
  logic             key_repeat_q;
  logic [7:0]       key_ascii_q;
  logic             key_down_q;
  logic [CNT_W-1:0] press_count_q;
  logic             held_ext_q;
  logic [7:0]       held_code_q;
  logic             shift_l_q, shift_r_q;
  logic             held_match_d;

  function automatic logic [7:0] ascii_of(input logic [7:0] b, input logic upper);
    logic [7:0] letter;
    logic [7:0] other;
    letter = 8'h00;
    other  = 8'h00;
    case (b)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      8'h45: other = 8'h30;  8'h16: other = 8'h31;  8'h1E: other = 8'h32;
      8'h26: other = 8'h33;  8'h25: other = 8'h34;  8'h2E: other = 8'h35;
      8'h36: other = 8'h36;  8'h3D: other = 8'h37;  8'h3E: other = 8'h38;
      8'h46: other = 8'h39;  8'h29: other = 8'h20;  8'h5A: other = 8'h0D;
      default: ;
    endcase
    return (letter != 8'h00) ? (upper ? letter - 8'h20 : letter) : other;
  endfunction

  // Prefix tracking: decides whether this byte completes an event and what kind.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    evt_fire_d = 1'b0;
    evt_ext_d  = 1'b0;
    evt_make_d = 1'b0;
    if (bus_if.code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.code == B_E0)      state_d = S_E0;
          else if (bus_if.code == B_F0) state_d = S_F0;
          else if (bus_if.code != 8'hAA && bus_if.code != 8'hFA && bus_if.code != 8'hFE) begin
            evt_fire_d = 1'b1;
            evt_make_d = 1'b1;
          end
        end
        S_E0: begin
          if (bus_if.code == B_F0)      state_d = S_E0F0;
          else if (bus_if.code != B_E0) begin
            state_d    = S_IDLE;
            evt_fire_d = 1'b1;
            evt_ext_d  = 1'b1;
            evt_make_d = 1'b1;
          end
        end
        S_F0: begin
          if (bus_if.code != B_F0) begin
            state_d    = S_IDLE;
            evt_fire_d = 1'b1;
          end
        end
        S_E0F0: begin
          if (bus_if.code != B_F0) begin
            state_d    = S_IDLE;
            evt_fire_d = 1'b1;
            evt_ext_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign held_match_d = ({held_ext_q, held_code_q} == {evt_ext_d, bus_if.code});

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_make_q    <= 1'b0;
      key_repeat_q  <= 1'b0;
      key_ascii_q   <= 8'h00;
      key_down_q    <= 1'b0;
      press_count_q <= '0;
      held_ext_q    <= 1'b0;
      held_code_q   <= 8'h00;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= evt_fire_d;
      if (evt_fire_d) begin
        key_code_q  <= bus_if.code;
        key_ext_q   <= evt_ext_d;
        key_make_q  <= evt_make_d;
        key_ascii_q <= evt_ext_d ? 8'h00 : ascii_of(bus_if.code, shift_l_q | shift_r_q);
        if (evt_make_d) begin
          if (key_down_q && held_match_d) begin
            key_repeat_q <= 1'b1;
          end else begin
            key_repeat_q  <= 1'b0;
            held_ext_q    <= evt_ext_d;
            held_code_q   <= bus_if.code;
            key_down_q    <= 1'b1;
            press_count_q <= press_count_q + CNT_W'(1);
          end
        end else begin
          key_repeat_q <= 1'b0;
          if (held_match_d) key_down_q <= 1'b0;
        end
        if (!evt_ext_d && bus_if.code == 8'h12) shift_l_q <= evt_make_d;
        if (!evt_ext_d && bus_if.code == 8'h59) shift_r_q <= evt_make_d;
      end
    end
  end

  assign bus_if.key_valid   = key_valid_q;
  assign bus_if.key_code    = key_code_q;
  assign bus_if.key_ext     = key_ext_q;
  assign bus_if.key_make    = key_make_q;
  assign bus_if.key_repeat  = key_repeat_q;
  assign bus_if.key_ascii   = key_ascii_q;
  assign bus_if.key_down    = key_down_q;
  assign bus_if.press_count = press_count_q;

endmodule
